// File: rtl/bcd_scan_counter.sv
// -----------------------------------------------------------------------------
// bcd_scan_counter
//
// Multi-digit synchronous BCD up/down counter with a time-multiplexed digit
// scanner. It sits upstream of a BCD-to-seven-segment decoder and presents one
// BCD digit at a time, together with a one-hot select for a common
// multiplexed display.
//
// Parameters
//   DIGITS    number of BCD digits (>= 1)
//   SCAN_DIV  clock cycles each digit is held on the scan outputs (>= 1)
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset
//   cnt_en     count strobe, one step per cycle while high
//   up         direction: 1 = up, 0 = down (only looked at with cnt_en)
//   load       synchronous load of load_bcd, has priority over cnt_en
//   load_bcd   load value, nibble k = digit k, digit 0 least significant
//   bcd_value  registered count, same nibble layout as load_bcd
//   carry      one-cycle pulse on a full-range wrap in either direction
//   digit      BCD digit currently scanned; wire it MSB first to the decoder
//              (i0 = digit[3], i3 = digit[0])
//   digit_sel  one-hot active-high select of the scanned digit
// -----------------------------------------------------------------------------
module bcd_scan_counter #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cnt_en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_bcd,
  output logic [4*DIGITS-1:0]   bcd_value,
  output logic                  carry,
  output logic [3:0]            digit,
  output logic [DIGITS-1:0]     digit_sel
);

  // Keep both counters at least one bit wide so DIGITS=1 / SCAN_DIV=1 still
  // elaborate; with those values the wrap compare is always true.
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;

  logic [4*DIGITS-1:0] bcd_q, bcd_next;
  logic                carry_q, carry_next;
  logic [DIV_W-1:0]    div_q, div_next;
  logic [IDX_W-1:0]    idx_q, idx_next;
  logic [DIGITS-1:0]   sel_q;

  logic                ripple;
  logic [3:0]          nib;

  // ---------------------------------------------------------------------------
  // Counter next-state: load > count > hold.
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    bcd_next   = bcd_q;
    carry_next = 1'b0;
    ripple     = 1'b0;
    nib        = '0;
    if (load) begin
      // Out-of-range nibbles are stored as 0 so the count stays valid BCD.
      for (int k = 0; k < DIGITS; k++) begin
        nib = load_bcd[4*k +: 4];
        bcd_next[4*k +: 4] = (nib > 4'd9) ? 4'd0 : nib;
      end
    end else if (cnt_en) begin
      // ripple is the carry/borrow into digit k; it starts as the +/-1 step
      // applied to digit 0 and whatever leaves the top digit is the wrap.
      ripple = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
        if (ripple) begin
          nib = bcd_q[4*k +: 4];
          if (up) begin
            if (nib == 4'd9) begin
              bcd_next[4*k +: 4] = 4'd0;
            end else begin
              bcd_next[4*k +: 4] = nib + 4'd1;
              ripple = 1'b0;
            end
          end else begin
            if (nib == 4'd0) begin
              bcd_next[4*k +: 4] = 4'd9;
            end else begin
              bcd_next[4*k +: 4] = nib - 4'd1;
              ripple = 1'b0;
            end
          end
        end
      end
      carry_next = ripple;
    end
  end

  // ---------------------------------------------------------------------------
  // Scanner next-state: free-running divider, index advances on divider wrap.
  // ---------------------------------------------------------------------------
  always_comb begin
    div_next = div_q + 1'b1;
    idx_next = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_next = '0;
      idx_next = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q   <= '0;
      carry_q <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
      sel_q   <= DIGITS'(1);
    end else begin
      bcd_q   <= bcd_next;
      carry_q <= carry_next;
      div_q   <= div_next;
      idx_q   <= idx_next;
      sel_q   <= DIGITS'(1) << idx_next;
    end
  end

  // Digit mux reads only registers, so a count or load shows on digit in the
  // same cycle it shows on bcd_value.
  always_comb begin
    digit = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) digit = bcd_q[4*k +: 4];
    end
  end

  assign bcd_value = bcd_q;
  assign carry     = carry_q;
  assign digit_sel = sel_q;

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
- Multi-digit synchronous BCD up/down counter with built-in time-multiplexed digit scanner.
- Sits directly upstream of the BCD-to-seven-segment decoder; presents one 4-bit BCD digit at a time plus a one-hot digit select for a common multiplexed display.
- The decoder's four inputs are driven from digit, MSB first: i0 = digit[3], i3 = digit[0].

Parameters:
- DIGITS, 4, number of BCD digits; DIGITS >= 1.
- SCAN_DIV, 1000, clock cycles each digit is held on the scan outputs; SCAN_DIV >= 1.

Ports:
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  asynchronous active-low reset.
- cnt_en  in  1  count strobe; one step per cycle while high.
- up  in  1  direction: 1 = count up, 0 = count down; sampled only with cnt_en.
- load  in  1  synchronous load of load_bcd; priority over cnt_en.
- load_bcd  in  4*DIGITS  load value; nibble k = digit k, digit 0 least significant.
- bcd_value  out  4*DIGITS  full registered count, same nibble layout.
- carry  out  1  one-cycle pulse on full-range wrap (either direction).
- digit  out  4  BCD digit currently scanned.
- digit_sel  out  DIGITS  one-hot active-high select of the scanned digit.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n. Assertion clears all state immediately, regardless of clk. Release takes effect at the next rising edge.
- Reset values:
  - bcd_value = 0.
  - carry = 0.
  - scan divider = 0.
  - scan index = 0.
  - digit_sel = 1 (digit 0 selected).
  - digit = 0.
- Per-edge priority: load > cnt_en > hold.
- Load:
  - bcd_value <= load_bcd, except that any nibble > 9 is stored as 0.
  - carry = 0 on a load cycle.
  - Load does not disturb the scanner.
- Count up (cnt_en=1, up=1):
  - Digit 0 increments; a digit at 9 becomes 0 and propagates +1 to the next digit, ripple within a single cycle.
  - All-9s -> all-0s sets carry = 1 for exactly that cycle.
- Count down (cnt_en=1, up=0):
  - Digit 0 decrements; a digit at 0 becomes 9 and propagates a borrow.
  - All-0s -> all-9s sets carry = 1 for exactly that cycle.
- carry timing: registered, high in the cycle after the wrapping edge's inputs; otherwise 0. A continuous cnt_en at the wrap point gives a single-cycle carry pulse per wrap.
- Invariant: bcd_value nibbles are always 0..9.
- Scanner:
  - Divider counts 0..SCAN_DIV-1 every cycle, free-running, independent of cnt_en and load.
  - When the divider equals SCAN_DIV-1, it wraps to 0 and the scan index advances; index DIGITS-1 wraps to 0.
  - SCAN_DIV = 1: index advances every cycle.
  - DIGITS = 1: index stays 0 and digit_sel stays 1.
- digit_sel: registered one-hot of the scan index; exactly one bit is high at all times after reset.
- digit: bcd_value nibble[scan index], driven only from registered state. A count or load edge is visible on digit in the same cycle it appears on bcd_value.
- Latency: bcd_value, carry, digit_sel all update on the edge following the input sample.
- Reset mid-count or mid-scan: all state returns to reset values immediately; no carry pulse is produced.

Test Plan (DIGITS=4, SCAN_DIV=4):
1. rst_n low, clk running -> bcd_value=0x0000, digit_sel=4'b0001, digit=0, carry=0. Release rst_n, hold 16 cycles -> digit_sel steps 0001,0010,0100,1000,0001 every 4 cycles.
2. load=1, load_bcd=0x0998, then cnt_en=1, up=1 for 3 cycles -> bcd_value 0x0999, 0x1000, 0x1001; carry stays 0.
3. Load 0x9998, cnt_en=1, up=1 for 3 cycles -> 0x9999, 0x0000 (carry=1 this cycle only), 0x0001.
4. Load 0x0001, cnt_en=1, up=0 for 3 cycles -> 0x0000, 0x9999 (carry=1 single cycle), 0x9998.
5. load=1 and cnt_en=1 in the same cycle with load_bcd=0x12F4 -> bcd_value=0x1204 (load wins, 0xF nibble forced to 0), carry=0, scan phase undisturbed.
6. Load 0x5678, run 16 cycles with cnt_en=0 -> digit reads 8,7,6,5 in lockstep with digit_sel 0001..1000. Assert rst_n mid-scan -> digit_sel=0001, bcd_value=0 asynchronously, before the next clk edge.
